// File: rtl/packet_xor_checksum_if.sv
// Stream bundle for packet_xor_checksum: upstream word beats and downstream results.
// slave = the checksum block, master = the source/sink around it.
interface packet_xor_checksum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_data;
    logic             up_last;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] down_checksum;
    logic             down_parity;
    logic [CNT_W-1:0] down_words;
    logic             down_sat;

    modport slave (
        input  up_valid, up_data, up_last, down_ready,
        output up_ready, down_valid, down_checksum,
        output down_parity, down_words, down_sat
    );

    modport master (
        output up_valid, up_data, up_last, down_ready,
        input  up_ready, down_valid, down_checksum,
        input  down_parity, down_words, down_sat
    );
endinterface

// File: rtl/packet_xor_checksum.sv
// Streaming XOR checksum: folds a packet of WIDTH-bit words into one word,
// its parity and a saturating word count. Ports: clk, rst (sync, high), bus.
module packet_xor_checksum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    packet_xor_checksum_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_acc_q, sat_acc_d;
    logic             down_valid_q, down_valid_d;
    logic [WIDTH-1:0] down_checksum_q, down_checksum_d;
    logic             down_parity_q, down_parity_d;
    logic [CNT_W-1:0] down_words_q, down_words_d;
    logic             down_sat_q, down_sat_d;

    logic             up_ready;
    logic             up_fire;
    logic [WIDTH-1:0] sum;
    logic             cnt_full;

    // A slot frees up in the same cycle the pending result is consumed.
    assign up_ready = !down_valid_q || bus.down_ready;
    assign up_fire  = bus.up_valid && up_ready;
    assign sum      = acc_q ^ bus.up_data;
    assign cnt_full = (cnt_q == CNT_MAX);

    always_comb begin
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        sat_acc_d       = sat_acc_q;
        down_valid_d    = down_valid_q;
        down_checksum_d = down_checksum_q;
        down_parity_d   = down_parity_q;
        down_words_d    = down_words_q;
        down_sat_d      = down_sat_q;

        if (down_valid_q && bus.down_ready) begin
            down_valid_d = 1'b0;
        end

        if (up_fire) begin
            if (bus.up_last) begin
                down_valid_d    = 1'b1;
                down_checksum_d = sum;
                down_parity_d   = ^sum;
                down_words_d    = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
                down_sat_d      = sat_acc_q || cnt_full;
                acc_d           = '0;
                cnt_d           = '0;
                sat_acc_d       = 1'b0;
            end else begin
                acc_d = sum;
                if (cnt_full) begin
                    sat_acc_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q           <= '0;
            cnt_q           <= '0;
            sat_acc_q       <= 1'b0;
            down_valid_q    <= 1'b0;
            down_checksum_q <= '0;
            down_parity_q   <= 1'b0;
            down_words_q    <= '0;
            down_sat_q      <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            sat_acc_q       <= sat_acc_d;
            down_valid_q    <= down_valid_d;
            down_checksum_q <= down_checksum_d;
            down_parity_q   <= down_parity_d;
            down_words_q    <= down_words_d;
            down_sat_q      <= down_sat_d;
        end
    end

    assign bus.up_ready      = up_ready;
    assign bus.down_valid    = down_valid_q;
    assign bus.down_checksum = down_checksum_q;
    assign bus.down_parity   = down_parity_q;
    assign bus.down_words    = down_words_q;
    assign bus.down_sat      = down_sat_q;
endmodule
